// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stage bus with flush and stall-counter sideband
interface pipe_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output in_valid, in_data, in_ctrl, out_ready, flush, cnt_clr,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready, flush, cnt_clr,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: skid-buffered pipeline register with flush bubbles and a saturating stall counter
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  logic              r_main_valid, r_skid_valid;
  logic [DATA_W-1:0] r_out_data, r_skid_data;
  logic [CTRL_W-1:0] r_out_ctrl, r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_accept, w_consume, w_load_main;
  assign w_accept    = bus.in_valid & ~r_skid_valid;
  assign w_consume   = r_main_valid & bus.out_ready;
  assign w_load_main = ~r_skid_valid & (~r_main_valid | w_consume);
  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
  assign bus.in_ready  = ~r_skid_valid;
  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ctrl  = r_out_ctrl;
  assign bus.stall_cnt = r_stall_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_out_ctrl   <= '0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_ctrl   <= '0;
      r_skid_ctrl  <= '0;
    end else if (r_skid_valid) begin
      if (w_consume) begin
        r_out_data   <= r_skid_data;
        r_out_ctrl   <= r_skid_ctrl;
        r_skid_valid <= 1'b0;
      end
    end else if (w_load_main) begin
      r_main_valid <= w_accept;
      r_out_ctrl   <= w_accept ? bus.in_ctrl : '0;
      if (w_accept) r_out_data <= bus.in_data;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= bus.in_data;
      r_skid_ctrl  <= bus.in_ctrl;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall_cnt <= '0;
    else if (bus.cnt_clr) r_stall_cnt <= '0;
    else if (r_main_valid & ~bus.out_ready & ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks against a queue-based reference model
module tb_pipe_stage_reg;
  localparam int DW = 96, CW = 12, NW = 4;
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  logic clk = 1'b0, reset = 1'b1;
  int n_chk = 0, n_pass = 0;
  ent_t q[$];
  logic [DW-1:0] m_last;
  int m_cnt, m_pushes;
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus ();
  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic mdl_reset();
    q = {};
    m_last = '0;
    m_cnt = 0;
  endtask
  // Stage modelled as a FIFO of depth 2: ready whenever fewer than two entries are held
  task automatic mdl_edge();
    bit rdy = q.size() < 2;
    bit stall = q.size() > 0 && !bus.out_ready;
    if (bus.cnt_clr) m_cnt = 0;
    else if (stall && m_cnt < (1 << NW) - 1) m_cnt++;
    if (bus.flush) q = {};
    else begin
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy) begin
        q.push_back('{d: bus.in_data, c: bus.in_ctrl});
        m_pushes++;
      end
    end
    if (q.size() > 0) m_last = q[0].d;
  endtask
  task automatic cmp_all();
    chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
    chk("out_data", 128'(bus.out_data), 128'(m_last));
    chk("out_ctrl", 128'(bus.out_ctrl), q.size() > 0 ? 128'(q[0].c) : 128'(0));
    chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
    chk("stall_cnt", 128'(bus.stall_cnt), 128'(m_cnt));
  endtask
  task automatic step();
    @(posedge clk);
    mdl_edge();
    #1 cmp_all();
  endtask
  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c, input bit r);
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_ctrl = c;
    bus.out_ready = r;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_ctrl"}, 128'(bus.out_ctrl), 128'(0));
    chk({tag, "_data"}, 128'(bus.out_data), 128'(0));
    chk({tag, "_cnt"}, 128'(bus.stall_cnt), 128'(0));
    chk({tag, "_rdy"}, 128'(bus.in_ready), 128'(1));
  endtask
  initial begin
    int cyc;
    drive(1'b1, 96'h5A, 12'hABC, 1'b0);
    bus.flush = 1'b0;
    bus.cnt_clr = 1'b0;
    m_pushes = 0;
    mdl_reset();
    #12 chk_zero("reset");
    @(negedge clk) reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 12'hFFF, 1'b1);
      step();
      chk("stream_data", 128'(bus.out_data), 128'(i));
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b1, 96'hA, 12'h00A, 1'b0);
    step();
    drive(1'b1, 96'hB, 12'h00B, 1'b0);
    step();
    chk("skid_full_rdy", 128'(bus.in_ready), 128'(0));
    drive(1'b1, 96'hC, 12'h00C, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1);
    step();
    chk("drain_a_to_b", 128'(bus.out_data), 128'(96'hB));
    step();
    step();
    drive(1'b1, 96'hA1, 12'h0A1, 1'b0);
    step();
    drive(1'b1, 96'hB1, 12'h0B1, 1'b0);
    step();
    drive(1'b1, 96'hC1, 12'h0C1, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_rdy", 128'(bus.in_ready), 128'(1));
    drive(1'b0, '0, '0, 1'b1);
    step();
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    drive(1'b1, 96'hD, 12'h00D, 1'b0);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", 128'(bus.stall_cnt), 128'(15));
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    chk("clr_over_inc", 128'(bus.stall_cnt), 128'(0));
    drive(1'b1, 96'hE, 12'h00E, 1'b0);
    step();
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_zero("async_rst");
    mdl_reset();
    @(negedge clk) reset = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    step();
    m_pushes = 0;
    cyc = 0;
    while (m_pushes < 1000 && cyc < 10000) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, CW'($urandom), 1'($urandom_range(0, 1)));
      bus.cnt_clr = ($urandom_range(0, 49) == 0);
      step();
      cyc++;
    end
    chk("rand_entries", 128'(m_pushes >= 1000), 128'(1));
    drive(1'b0, '0, '0, 1'b1);
    bus.cnt_clr = 1'b0;
    cyc = 0;
    while (bus.out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk("drained", 128'(bus.out_valid), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  always @(negedge clk) if (!reset && !bus.out_valid && bus.out_ctrl !== '0)
    $display("FAIL bubble_ctrl: got %0h expected 0", bus.out_ctrl);
endmodule
